mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory initiator: turns a load/store request into an aligned dcache transaction.
//  Builds the byte-enable mask and byte-replicated write data for stores.
//  Issues the read/write, holds it until dmem_resp, and latches the raw read word.
//  Hands mdr_out and rmask to writeback, which extracts and sign/zero-extends the loaded bytes.
// PARAMETERS
//  TIMEOUT  0  cycles to wait for dmem_resp before raising fault; 0 = wait forever
// PORTS
//  clk              in   1   clock; single clock domain
//  rst              in   1   reset, asynchronous, active-high
//  req_valid        in   1   request present; accepted when req_valid && ready
//  req_is_load      in   1   request is a load
//  req_is_store     in   1   request is a store
//  funct3           in   3   000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
//  addr             in   32  byte address (ALU result)
//  store_data       in   32  rs2 value; the low byte/half/word is used
//  ready            out  1   unit idle, can accept a request
//  done             out  1   one-cycle pulse: the transaction has finished
//  fault            out  1   valid with done: misaligned, illegal, or timed out; held until next accept
//  mdr_out          out  32  raw dmem_rdata word latched on load completion
//  rmask            out  4   byte lanes of the load, for writeback extraction
//  wmask            out  4   byte lanes written by the store
//  dmem_read        out  1   dcache read request; held until dmem_resp
//  dmem_write       out  1   dcache write request; held until dmem_resp
//  dmem_address     out  32  {addr[31:2],2'b00}
//  dmem_wdata       out  32  aligned write data
//  dmem_byte_enable out  4   wmask for stores, rmask for loads
//  dmem_resp        in   1   dcache completion, one cycle
//  dmem_rdata       in   32  read data; valid only while dmem_resp is high
// BEHAVIOUR
//  Reset (async): state IDLE, wait counter 0; all outputs 0 except ready=1.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE, on accept: latch address/masks/wdata/type.
//   - Legal request -> ACCESS.
//   - Fault condition -> DONE with fault=1 and no dcache traffic.
//  Fault conditions:
//   - h/hu with addr[0]=1, or w with addr[1:0]!=0.
//   - funct3 outside the legal set, or bu/hu on a store.
//   - req_is_load and req_is_store both high, or both low.
//  ACCESS:
//   - dmem_read or dmem_write=1 from registered state; address, wdata and byte_enable stable.
//   - dmem_resp=1: load latches mdr_out<=dmem_rdata -> DONE. Earliest completion is 2 cycles after accept.
//   - TIMEOUT!=0 and counter reaches TIMEOUT: drop request, fault=1 -> DONE.
//  DONE: done=1 for exactly one cycle, then -> IDLE. ready=0 during ACCESS and DONE.
//  Masks: b/bu 4'b0001<<addr[1:0]; h/hu 4'b0011<<addr[1:0]; w 4'b1111.
//   - rmask is set for loads and 0 for stores; wmask the reverse.
//  Write data: sb {4{store_data[7:0]}}, sh {2{store_data[15:0]}}, sw store_data.
//  Result hold: mdr_out, rmask, wmask and fault hold their values until the next accept.
//  Edge cases:
//   - dmem_resp in IDLE or DONE is ignored.
//   - req_valid while not ready is not accepted; the requester holds it.
//   - rst during ACCESS: request dropped at once, no done pulse.
// TESTING
//  sb, addr=0x1003, data=0xAB -> dmem_address 0x1000, byte_enable 1000, wdata 0xABABABAB, done 1 cycle after resp.
//  lh, addr=0x2002; dcache resp 3 cycles later with 0x8001_7FFF -> mdr_out 0x80017FFF, rmask 1100, fault 0.
//  lw, addr=0x3001 -> no dmem_read ever, done 1 cycle after accept, fault=1.
//  TIMEOUT=4, sw with no resp -> dmem_write high 4 cycles then drops, done with fault=1.
//  rst asserted mid-ACCESS -> dmem_read/dmem_write fall immediately, ready=1, no done; next request OK.
//  Back-to-back: new req_valid held during DONE is accepted the cycle ready returns; stray resp in IDLE ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: turns a load/store request into one aligned
// dcache transaction and hands the raw read word and lane mask to writeback.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [31:0] mdr_out,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_waitCount;
  logic        r_isLoad;

  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic        w_legal;
  logic        w_misaligned;
  logic        w_loadOnly;
  logic        w_fault;
  logic        w_accept;
  logic        w_timeoutHit;

  // Decode access size into lane mask, replicated store data and alignment check.
  always_comb begin
    w_mask       = 4'b0000;
    w_wdata      = store_data;
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    w_loadOnly   = 1'b0;
    unique case (funct3)
      3'b000, 3'b100: begin
        w_legal    = 1'b1;
        w_loadOnly = funct3[2];
        w_mask     = 4'b0001 << addr[1:0];
        w_wdata    = {4{store_data[7:0]}};
      end
      3'b001, 3'b101: begin
        w_legal      = 1'b1;
        w_loadOnly   = funct3[2];
        w_misaligned = addr[0];
        w_mask       = 4'b0011 << addr[1:0];
        w_wdata      = {2{store_data[15:0]}};
      end
      3'b010: begin
        w_legal      = 1'b1;
        w_misaligned = |addr[1:0];
        w_mask       = 4'b1111;
        w_wdata      = store_data;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_fault = (req_is_load == req_is_store) || !w_legal || w_misaligned ||
                   (w_loadOnly && req_is_store);
  assign w_accept = req_valid && ready && (r_state == IDLE);
  assign w_timeoutHit = (TIMEOUT != 0) && (r_waitCount == 32'(TIMEOUT - 1));

  // Faulting requests skip the dcache entirely and go straight to the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_waitCount      <= '0;
      r_isLoad         <= 1'b0;
      ready            <= 1'b1;
      done             <= 1'b0;
      fault            <= 1'b0;
      mdr_out          <= '0;
      rmask            <= '0;
      wmask            <= '0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            ready        <= 1'b0;
            r_waitCount  <= '0;
            r_isLoad     <= req_is_load;
            mdr_out      <= '0;
            dmem_address <= {addr[31:2], 2'b00};
            if (w_fault) begin
              fault            <= 1'b1;
              done             <= 1'b1;
              rmask            <= '0;
              wmask            <= '0;
              dmem_byte_enable <= '0;
              dmem_wdata       <= '0;
              r_state          <= DONE;
            end else begin
              fault            <= 1'b0;
              rmask            <= req_is_load ? w_mask : 4'b0000;
              wmask            <= req_is_store ? w_mask : 4'b0000;
              dmem_byte_enable <= w_mask;
              dmem_wdata       <= req_is_store ? w_wdata : 32'h0;
              dmem_read        <= req_is_load;
              dmem_write       <= req_is_store;
              r_state          <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A response arriving on the timeout cycle still completes normally.
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (r_isLoad) begin
              mdr_out <= dmem_rdata;
            end
            done    <= 1'b1;
            r_state <= DONE;
          end else if (w_timeoutHit) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            fault      <= 1'b1;
            done       <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_waitCount <= r_waitCount + 32'd1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit, checked against a
// transaction-level model of the load/store rules.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        ready;
  logic        done;
  logic        fault;
  logic [31:0] mdr_out;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  logic        expFault;
  logic [31:0] expAddr;
  logic [3:0]  expRmask;
  logic [3:0]  expWmask;
  logic [31:0] expWdata;
  logic        expIsLoad;
  logic [31:0] mdrModel;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_load(req_is_load),
    .req_is_store(req_is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .ready(ready), .done(done), .fault(fault), .mdr_out(mdr_out), .rmask(rmask),
    .wmask(wmask), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: lane count, alignment and replication by arithmetic.
  task automatic modelRequest(input logic [2:0] f3, input bit ld, input bit st,
                              input logic [31:0] a, input logic [31:0] d);
    int bytes;
    int off;
    int m;
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    bytes = 1 << int'(f3[1:0]);
    off = int'(a % 4);
    expFault = (ld == st) || !legal || (st && f3[2]) || ((a % bytes) != 0);
    expAddr = a - 32'(off);
    m = ((1 << bytes) - 1) << off;
    expRmask = (!expFault && ld) ? 4'(m) : 4'd0;
    expWmask = (!expFault && st) ? 4'(m) : 4'd0;
    if (bytes == 1) expWdata = d[7:0] * 32'h01010101;
    else if (bytes == 2) expWdata = d[15:0] * 32'h00010001;
    else expWdata = d;
    expIsLoad = ld;
  endtask

  task automatic driveRequest(input logic [2:0] f3, input bit ld, input bit st,
                              input logic [31:0] a, input logic [31:0] d);
    funct3 = f3;
    req_is_load = ld;
    req_is_store = st;
    addr = a;
    store_data = d;
    req_valid = 1'b1;
    modelRequest(f3, ld, st, a, d);
  endtask

  task automatic waitReady();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput("readyWait", ready, 1);
  endtask

  // Entered at the negedge right after the accepting edge.
  task automatic finishRequest(input int delay, input bit noResp, input logic [31:0] rdata,
                               input string tag);
    logic strobe;
    checkOutput({tag, "_busy"}, ready, 0);
    if (expFault) begin
      checkOutput({tag, "_fdone"}, done, 1);
      checkOutput({tag, "_ffault"}, fault, 1);
      checkOutput({tag, "_fnotraffic"}, {dmem_read, dmem_write}, 0);
      checkOutput({tag, "_fmasks"}, {rmask, wmask}, 0);
      mdrModel = 32'h0;
      @(negedge clk);
      checkOutput({tag, "_fpulse"}, done, 0);
      checkOutput({tag, "_fready"}, ready, 1);
      checkOutput({tag, "_fhold"}, fault, 1);
    end else begin
      checkOutput({tag, "_strobes"}, {dmem_read, dmem_write}, {expIsLoad, !expIsLoad});
      checkOutput({tag, "_addr"}, dmem_address, expAddr);
      checkOutput({tag, "_be"}, dmem_byte_enable, expIsLoad ? expRmask : expWmask);
      if (!expIsLoad) checkOutput({tag, "_wdata"}, dmem_wdata, expWdata);
      checkOutput({tag, "_early"}, done, 0);
      if (noResp) begin
        for (int i = 1; i < int'(TIMEOUT); i++) begin
          @(negedge clk);
          strobe = expIsLoad ? dmem_read : dmem_write;
          checkOutput({tag, "_wait"}, strobe, 1);
        end
        @(negedge clk);
        checkOutput({tag, "_tdrop"}, {dmem_read, dmem_write}, 0);
        checkOutput({tag, "_tdone"}, done, 1);
        checkOutput({tag, "_tfault"}, fault, 1);
        mdrModel = 32'h0;
      end else begin
        repeat (delay) begin
          @(negedge clk);
          strobe = expIsLoad ? dmem_read : dmem_write;
          checkOutput({tag, "_hold"}, strobe, 1);
          checkOutput({tag, "_nodone"}, done, 0);
        end
        dmem_resp = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_resp = 1'b0;
        dmem_rdata = $urandom;
        if (expIsLoad) mdrModel = rdata;
        else mdrModel = 32'h0;
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_fault"}, fault, 0);
        checkOutput({tag, "_drop"}, {dmem_read, dmem_write}, 0);
        checkOutput({tag, "_mdr"}, mdr_out, mdrModel);
        checkOutput({tag, "_rmask"}, rmask, expRmask);
        checkOutput({tag, "_wmask"}, wmask, expWmask);
      end
      @(negedge clk);
      checkOutput({tag, "_pulse"}, done, 0);
      checkOutput({tag, "_ready"}, ready, 1);
      checkOutput({tag, "_mdrhold"}, mdr_out, mdrModel);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input bit ld, input bit st,
                               input logic [31:0] a, input logic [31:0] d, input int delay,
                               input bit noResp, input logic [31:0] rdata, input string tag);
    waitReady();
    driveRequest(f3, ld, st, a, d);
    @(negedge clk);
    req_valid = 1'b0;
    finishRequest(delay, noResp, rdata, tag);
  endtask

  initial begin
    bit ld;
    bit st;
    logic [2:0] f3;
    int pick;
    rst = 1'b1;
    req_valid = 1'b0;
    req_is_load = 1'b0;
    req_is_store = 1'b0;
    funct3 = 3'd0;
    addr = 32'h0;
    store_data = 32'h0;
    dmem_resp = 1'b0;
    dmem_rdata = 32'h0;
    mdrModel = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_strobes", {dmem_read, dmem_write}, 0);
    checkOutput("rst_mdr", mdr_out, 0);
    checkOutput("rst_masks", {rmask, wmask, dmem_byte_enable}, 0);
    checkOutput("rst_addr", dmem_address, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(3'b000, 0, 1, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, "sb");
    checkOutput("sb_lane", wmask, 4'b1000);
    applyStimulus(3'b001, 1, 0, 32'h0000_2002, 32'h0, 2, 0, 32'h8001_7FFF, "lh");
    checkOutput("lh_word", mdr_out, 32'h8001_7FFF);
    checkOutput("lh_lane", rmask, 4'b1100);
    applyStimulus(3'b010, 1, 0, 32'h0000_3001, 32'h0, 0, 0, 32'h0, "lwmis");
    applyStimulus(3'b010, 0, 1, 32'h0000_4000, 32'h1234_5678, 0, 1, 32'h0, "swtmo");

    // Reset in the middle of an access drops it with no done pulse.
    waitReady();
    driveRequest(3'b010, 1, 0, 32'h0000_5000, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mid_read", dmem_read, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_drop", {dmem_read, dmem_write}, 0);
    checkOutput("mid_ready", ready, 1);
    checkOutput("mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    mdrModel = 32'h0;
    @(negedge clk);
    checkOutput("mid_nodone", done, 0);
    applyStimulus(3'b100, 1, 0, 32'h0000_6002, 32'h0, 1, 0, 32'hCAFE_F00D, "postrst");

    // Request held through DONE is taken the cycle ready returns.
    waitReady();
    driveRequest(3'b001, 1, 0, 32'h0000_7001, 32'h0);
    @(negedge clk);
    checkOutput("b2b_fdone", done, 1);
    checkOutput("b2b_ffault", fault, 1);
    driveRequest(3'b100, 1, 0, 32'h0000_7005, 32'h0);
    @(negedge clk);
    checkOutput("b2b_ready", ready, 1);
    checkOutput("b2b_notyet", dmem_read, 0);
    @(negedge clk);
    req_valid = 1'b0;
    finishRequest(1, 0, 32'h1122_3344, "b2b");

    dmem_resp = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_resp = 1'b0;
    checkOutput("stray_mdr", mdr_out, mdrModel);
    checkOutput("stray_done", done, 0);
    checkOutput("stray_ready", ready, 1);
    checkOutput("stray_read", dmem_read, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        ld = $urandom_range(0, 1) == 1;
        st = !ld;
      end else begin
        ld = $urandom_range(0, 1) == 1;
        st = ld;
      end
      if ($urandom_range(0, 9) < 7) begin
        pick = $urandom_range(0, 4);
        f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      applyStimulus(f3, ld, st, $urandom, $urandom, $urandom_range(0, 3), 0, $urandom,
                    $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
